multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Moore-style FSM control unit (one Mealy term, the branch PC write) for the 24-bit multi-cycle CPU.
- Sequences fetch/decode/execute/memory/write-back for each instruction.
- Drives IR write, PC mux and enable, ALU input selects, ALU operation, data-RAM strobes and register-file write.
- Sits between the instruction decoder (opcode) and the datapath (ALU zero flag).

Parameters:
- WIDTH_OPCODE, 5, opcode field width.
- ALU_OP_WIDTH, 4, width of ALUop.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  WIDTH_OPCODE  opcode from the decoder. Held stable by the IR after FETCH.
- zero  input  1  ALU result == 0, combinational from the ALU.
- IR_Write  output  1  load instruction register.
- MemToReg  output  1  1 = reg-file data from the memory register; 0 = from the ALU register.
- Mem_Read_not_Write  output  1  1 = read, 0 = write.
- Mem_Select  output  1  data-RAM chip select.
- PC_Source  output  2  0 = ALU out, 1 = ALU register, 2 = jump address, 3 = reset address.
- pc_write_enable  output  1  PC load.
- alu_src_a  output  1  0 = PC, 1 = rs1.
- alu_src_b  output  2  0 = rs2, 1 = constant 1, 2 = immediate, 3 = constant 1023.
- ALUop  output  ALU_OP_WIDTH  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- RegWrite  output  1  register-file write enable.

Behaviour:
- Opcodes: 0x00 NOP, 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 ADDI, 0x07 LW, 0x08 SW, 0x09 BEQ, 0x0A BNE, 0x0B JMP, 0x1F HALT. Any other opcode is illegal and acts as NOP.
- Default output values in every state unless overridden:
  - All enables are 0: IR_Write, Mem_Select, pc_write_enable, RegWrite.
  - Mem_Read_not_Write=1, MemToReg=0, PC_Source=0, alu_src_a=0, alu_src_b=0, ALUop=ADD.
- While reset is low: the state is forced to RST immediately (asynchronously), so outputs are RST's values.
- RST: PC_Source=3, pc_write_enable=1. Next state FETCH.
- FETCH: IR_Write=1, alu_src_a=0, alu_src_b=1, ALUop=ADD, PC_Source=0, pc_write_enable=1 (PC <= PC+1). Next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=2, ALUop=ADD, precomputing the branch target into the ALU register. Next state by opcode:
  - ADD/SUB/AND/OR/XOR -> EXEC_R.
  - ADDI -> EXEC_I.
  - LW/SW -> MEM_ADDR.
  - BEQ/BNE -> BRANCH.
  - JMP -> JUMP.
  - HALT -> see Optional Feature.
  - NOP/illegal -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, ALUop per opcode (ADD 0, SUB 1, AND 2, OR 3, XOR 4). Next state ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2, ALUop=ADD. Next state ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ALUop=ADD. Next state MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: Mem_Select=1, Mem_Read_not_Write=1. Next state MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1. Next state FETCH.
- MEM_WRITE: Mem_Select=1, Mem_Read_not_Write=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, ALUop=SUB, PC_Source=1.
  - pc_write_enable = zero for BEQ, ~zero for BNE. This is combinational (Mealy).
  - Next state FETCH.
- JUMP: PC_Source=2, pc_write_enable=1. Next state FETCH.
- Instruction cycle counts: R-type/ADDI 4, LW 5, SW 4, BEQ/BNE 3, JMP 3, NOP 2 (plus one RST cycle after reset release).
- Opcode is sampled only in DECODE and MEM_ADDR. Opcode changes in other states are ignored.
- RegWrite and Mem_Select are never asserted in the same cycle. pc_write_enable is never asserted in ALU_WB, MEM_*, EXEC_*.
- Reset asserted mid-instruction: the instruction is aborted and no partial write is issued once reset is low.
- Outputs are decoded from registered state. Only pc_write_enable in BRANCH depends on an input.

Optional Feature:
- Macro CONTROL_HALT_EN.
- Defined:
  - HALT (0x1F) in DECODE goes to state HALT.
  - In HALT all enables are 0 and the FSM stays there until reset.
- Undefined:
  - 0x1F is illegal and behaves as NOP (DECODE -> FETCH).
  - The HALT state does not exist.

Test Plan:
- Reset low then release -> cycle 1 RST: PC_Source=3, pc_write_enable=1. Cycle 2 FETCH: IR_Write=1, alu_src_b=1, pc_write_enable=1.
- opcode=0x02 (SUB) -> DECODE, EXEC_R with ALUop=1, alu_src_a=1, alu_src_b=0. ALU_WB with RegWrite=1, MemToReg=0. Then FETCH.
- opcode=0x07 (LW) -> MEM_ADDR with alu_src_b=2. MEM_READ with Mem_Select=1, Mem_Read_not_Write=1. MEM_WB with RegWrite=1, MemToReg=1. 5 cycles total.
- opcode=0x08 (SW) -> MEM_WRITE with Mem_Select=1, Mem_Read_not_Write=0, RegWrite=0.
- BEQ with zero=1 -> BRANCH: pc_write_enable=1, PC_Source=1. BEQ with zero=0 -> pc_write_enable=0. BNE -> inverse of BEQ.
- opcode=0x1F -> with CONTROL_HALT_EN the FSM holds in HALT for 100 cycles with all enables 0, and reset recovers to RST. Without the macro it returns to FETCH after 2 cycles.

Source files
------------

// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the CPU datapath.
// Master = control unit (drives strobes), slave = decoder/datapath side.
`timescale 1ns/1ps
interface multi_cycle_control_if #(
    parameter int WIDTH_OPCODE = 5,
    parameter int ALU_OP_WIDTH = 4
);
    logic [WIDTH_OPCODE-1:0] opcode;
    logic                    zero;
    logic                    IR_Write;
    logic                    MemToReg;
    logic                    Mem_Read_not_Write;
    logic                    Mem_Select;
    logic [1:0]              PC_Source;
    logic                    pc_write_enable;
    logic                    alu_src_a;
    logic [1:0]              alu_src_b;
    logic [ALU_OP_WIDTH-1:0] ALUop;
    logic                    RegWrite;

    modport master (
        input  opcode, zero,
        output IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select,
        output PC_Source, pc_write_enable, alu_src_a, alu_src_b,
        output ALUop, RegWrite
    );

    modport slave (
        output opcode, zero,
        input  IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select,
        input  PC_Source, pc_write_enable, alu_src_a, alu_src_b,
        input  ALUop, RegWrite
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/write-back.
// Optional CONTROL_HALT_EN adds a sticky HALT state for opcode 0x1F.
`timescale 1ns/1ps
module multi_cycle_control #(
    parameter int WIDTH_OPCODE = 5,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_cycle_control_if.master bus
);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(5'h01);
    localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(5'h02);
    localparam logic [WIDTH_OPCODE-1:0] OP_AND  = WIDTH_OPCODE'(5'h03);
    localparam logic [WIDTH_OPCODE-1:0] OP_OR   = WIDTH_OPCODE'(5'h04);
    localparam logic [WIDTH_OPCODE-1:0] OP_XOR  = WIDTH_OPCODE'(5'h05);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADDI = WIDTH_OPCODE'(5'h06);
    localparam logic [WIDTH_OPCODE-1:0] OP_LW   = WIDTH_OPCODE'(5'h07);
    localparam logic [WIDTH_OPCODE-1:0] OP_SW   = WIDTH_OPCODE'(5'h08);
    localparam logic [WIDTH_OPCODE-1:0] OP_BEQ  = WIDTH_OPCODE'(5'h09);
    localparam logic [WIDTH_OPCODE-1:0] OP_BNE  = WIDTH_OPCODE'(5'h0A);
    localparam logic [WIDTH_OPCODE-1:0] OP_JMP  = WIDTH_OPCODE'(5'h0B);
`ifdef CONTROL_HALT_EN
    localparam logic [WIDTH_OPCODE-1:0] OP_HALT = WIDTH_OPCODE'(5'h1F);
`endif

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = ALU_OP_WIDTH'(4);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP
`ifdef CONTROL_HALT_EN
        , S_HALT
`endif
    } state_t;

    state_t                  state, state_n;
    logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_n;
    logic                    bne_q;

    always_comb begin
        alu_op_n = ALU_ADD;
        case (bus.opcode)
            OP_SUB:  alu_op_n = ALU_SUB;
            OP_AND:  alu_op_n = ALU_AND;
            OP_OR:   alu_op_n = ALU_OR;
            OP_XOR:  alu_op_n = ALU_XOR;
            default: alu_op_n = ALU_ADD;
        endcase
    end

    // ALU op and branch sense are captured in DECODE so later opcode noise is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RST;
            alu_op_q <= ALU_ADD;
            bne_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) begin
                alu_op_q <= alu_op_n;
                bne_q    <= (bus.opcode == OP_BNE);
            end
        end
    end

    always_comb begin
        state_n                = state;
        bus.IR_Write           = 1'b0;
        bus.MemToReg           = 1'b0;
        bus.Mem_Read_not_Write = 1'b1;
        bus.Mem_Select         = 1'b0;
        bus.PC_Source          = 2'd0;
        bus.pc_write_enable    = 1'b0;
        bus.alu_src_a          = 1'b0;
        bus.alu_src_b          = 2'd0;
        bus.ALUop              = ALU_ADD;
        bus.RegWrite           = 1'b0;
        unique case (state)
            S_RST: begin
                bus.PC_Source       = 2'd3;
                bus.pc_write_enable = 1'b1;
                state_n             = S_FETCH;
            end
            S_FETCH: begin
                bus.IR_Write        = 1'b1;
                bus.alu_src_b       = 2'd1;
                bus.pc_write_enable = 1'b1;
                state_n             = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd2;
                case (bus.opcode)
                    OP_ADD, OP_SUB, OP_AND,
                    OP_OR, OP_XOR:   state_n = S_EXEC_R;
                    OP_ADDI:         state_n = S_EXEC_I;
                    OP_LW, OP_SW:    state_n = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_n = S_BRANCH;
                    OP_JMP:          state_n = S_JUMP;
`ifdef CONTROL_HALT_EN
                    OP_HALT:         state_n = S_HALT;
`endif
                    default:         state_n = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.ALUop     = alu_op_q;
                state_n       = S_ALU_WB;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                state_n       = S_ALU_WB;
            end
            S_ALU_WB: begin
                bus.RegWrite = 1'b1;
                state_n      = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                state_n = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.Mem_Select = 1'b1;
                state_n        = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b1;
                state_n      = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.Mem_Select         = 1'b1;
                bus.Mem_Read_not_Write = 1'b0;
                state_n                = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a       = 1'b1;
                bus.ALUop           = ALU_SUB;
                bus.PC_Source       = 2'd1;
                bus.pc_write_enable = bne_q ? ~bus.zero : bus.zero;
                state_n             = S_FETCH;
            end
            S_JUMP: begin
                bus.PC_Source       = 2'd2;
                bus.pc_write_enable = 1'b1;
                state_n             = S_FETCH;
            end
`ifdef CONTROL_HALT_EN
            S_HALT: state_n = S_HALT;
`endif
            default: state_n = S_RST;
        endcase
    end
endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control against a per-instruction
// cycle-sequence model; honours CONTROL_HALT_EN like the design.
`timescale 1ns/1ps
module tb_multi_cycle_control;
    typedef struct packed {
        logic       ir;
        logic       m2r;
        logic       rnw;
        logic       msel;
        logic [1:0] ps;
        logic       pcwe;
        logic       srca;
        logic [1:0] sb;
        logic [3:0] alu;
        logic       rw;
    } ctl_t;

    localparam int K_NOP  = 0;
    localparam int K_R    = 1;
    localparam int K_I    = 2;
    localparam int K_LW   = 3;
    localparam int K_SW   = 4;
    localparam int K_BR   = 5;
    localparam int K_J    = 6;
    localparam int K_HALT = 7;
    localparam int HALT_CYCLES = 100;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    multi_cycle_control_if #(.WIDTH_OPCODE(5), .ALU_OP_WIDTH(4)) bus ();

    multi_cycle_control #(.WIDTH_OPCODE(5), .ALU_OP_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t o;
        o.ir   = bus.IR_Write;
        o.m2r  = bus.MemToReg;
        o.rnw  = bus.Mem_Read_not_Write;
        o.msel = bus.Mem_Select;
        o.ps   = bus.PC_Source;
        o.pcwe = bus.pc_write_enable;
        o.srca = bus.alu_src_a;
        o.sb   = bus.alu_src_b;
        o.alu  = bus.ALUop;
        o.rw   = bus.RegWrite;
        return o;
    endfunction

    function automatic int kind_of(input logic [4:0] op);
        if (op >= 5'h01 && op <= 5'h05) return K_R;
        if (op == 5'h06) return K_I;
        if (op == 5'h07) return K_LW;
        if (op == 5'h08) return K_SW;
        if (op == 5'h09 || op == 5'h0A) return K_BR;
        if (op == 5'h0B) return K_J;
`ifdef CONTROL_HALT_EN
        if (op == 5'h1F) return K_HALT;
`endif
        return K_NOP;
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        case (kind_of(op))
            K_R, K_I, K_SW: return 4;
            K_LW:           return 5;
            K_BR, K_J:      return 3;
            K_HALT:         return 2 + HALT_CYCLES;
            default:        return 2;
        endcase
    endfunction

    function automatic ctl_t idle_out();
        ctl_t e;
        e     = '0;
        e.rnw = 1'b1;
        return e;
    endfunction

    function automatic ctl_t rst_out();
        ctl_t e;
        e      = idle_out();
        e.ps   = 2'd3;
        e.pcwe = 1'b1;
        return e;
    endfunction

    // Expected control word for cycle k of an instruction with opcode op.
    function automatic ctl_t exp_out(input logic [4:0] op, input int k,
                                     input logic z);
        ctl_t e;
        int   kd;
        e  = idle_out();
        kd = kind_of(op);
        if (k == 0) begin
            e.ir = 1'b1; e.sb = 2'd1; e.pcwe = 1'b1;
            return e;
        end
        if (k == 1) begin
            e.sb = 2'd2;
            return e;
        end
        case (kd)
            K_R: if (k == 2) begin
                e.srca = 1'b1; e.alu = 4'(op - 5'd1);
            end else e.rw = 1'b1;
            K_I: if (k == 2) begin
                e.srca = 1'b1; e.sb = 2'd2;
            end else e.rw = 1'b1;
            K_LW: if (k == 2) begin
                e.srca = 1'b1; e.sb = 2'd2;
            end else if (k == 3) e.msel = 1'b1;
            else begin
                e.rw = 1'b1; e.m2r = 1'b1;
            end
            K_SW: if (k == 2) begin
                e.srca = 1'b1; e.sb = 2'd2;
            end else begin
                e.msel = 1'b1; e.rnw = 1'b0;
            end
            K_BR: begin
                e.srca = 1'b1; e.alu = 4'd1; e.ps = 2'd1;
                e.pcwe = (op == 5'h09) ? z : ~z;
            end
            K_J: begin
                e.ps = 2'd2; e.pcwe = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        #1 check("rst_async", 32'(obs()), 32'(rst_out()));
        @(negedge clk);
        check("rst_hold", 32'(obs()), 32'(rst_out()));
        reset = 1'b1;
        #1 check("rst_release", 32'(obs()), 32'(rst_out()));
    endtask

    // zmode: 0/1 forces zero, 2 randomizes it each cycle.
    task automatic run_instr(input logic [4:0] op, input int zmode,
                             input bit may_abort);
        int len;
        len = instr_len(op);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 1 || (k == 2 && (kind_of(op) == K_LW ||
                                      kind_of(op) == K_SW)))
                bus.opcode = op;
            else
                bus.opcode = 5'($urandom);
            bus.zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            #1;
            check($sformatf("op%02h_c%0d", op, k), 32'(obs()),
                  32'(exp_out(op, k, bus.zero)));
            if (may_abort && k < len - 1 && $urandom_range(0, 19) == 0) begin
                do_reset();
                return;
            end
        end
        if (kind_of(op) == K_HALT) do_reset();
    endtask

    initial begin
        logic [4:0] op;
        bus.opcode = 5'h00;
        bus.zero   = 1'b0;
        #2;
        do_reset();

        run_instr(5'h02, 2, 1'b0);
        run_instr(5'h07, 2, 1'b0);
        run_instr(5'h08, 2, 1'b0);
        run_instr(5'h09, 1, 1'b0);
        run_instr(5'h09, 0, 1'b0);
        run_instr(5'h0A, 1, 1'b0);
        run_instr(5'h0A, 0, 1'b0);
        for (int i = 1; i <= 6; i++) run_instr(5'(i), 2, 1'b0);
        run_instr(5'h0B, 2, 1'b0);
        run_instr(5'h00, 2, 1'b0);
        run_instr(5'h0C, 2, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom);
            else op = 5'($urandom_range(0, 11));
            if (op == 5'h1F) op = 5'h00;
            run_instr(op, 2, 1'b1);
        end

        run_instr(5'h1F, 2, 1'b0);
        run_instr(5'h01, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
